// File: rtl/edge_det_pkg.sv
// edge_det_pkg: shared mode encoding for the multi-channel edge detector
package edge_det_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH} mode_e;
endpackage

// File: rtl/edge_det_ch.sv
// edge_det_ch: one channel of synchroniser, stability filter, edge qualifier, sticky flag and counter
module edge_det_ch
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sig,
  input  logic [MODE_W-1:0] mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              clr,
  output logic              pulse_sig,
  output logic              pulse_dir,
  output logic              sticky,
  output logic [CNT_W-1:0]  evt_cnt
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      stab_q, stab_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d, pulse_q, pulse_d, dir_q, dir_d, sticky_q, sticky_d;
  logic                   s, upd;
  mode_e                  m;
  // An update fires once the synchronised level has differed from filt for filt_len+1 cycles;
  // pulses come only from updates, so enabling a channel never replays stale history.
  always_comb begin
    s        = sync_q[SYNC_STAGES-1];
    m        = mode_e'(mode);
    upd      = (s != filt_q) && (stab_q >= filt_len);
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig};
    filt_d   = upd ? s : filt_q;
    stab_d   = (s == filt_q || upd) ? '0 : stab_q + 1'b1;
    pulse_d  = upd && (m == EDGE_BOTH || m == (s ? EDGE_RISE : EDGE_FALL));
    dir_d    = upd ? s : dir_q;
    sticky_d = pulse_q | (sticky_q & ~clr);
    cnt_d    = clr ? CNT_W'(pulse_q) : (pulse_q && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  // All channel state, cleared asynchronously so an in-flight filter count is lost on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q   <= '0;
      stab_q   <= '0;
      cnt_q    <= '0;
      filt_q   <= 1'b0;
      pulse_q  <= 1'b0;
      dir_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stab_q   <= stab_d;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      pulse_q  <= pulse_d;
      dir_q    <= dir_d;
      sticky_q <= sticky_d;
    end
  end
  assign pulse_sig = pulse_q;
  assign pulse_dir = dir_q;
  assign sticky    = sticky_q;
  assign evt_cnt   = cnt_q;
endmodule

// File: rtl/multi_edge_det.sv
// multi_edge_det: N_CH independent filtered edge detectors sharing one filter length
module multi_edge_det
  import edge_det_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_CH-1:0]        sig,
  input  logic [MODE_W*N_CH-1:0] mode,
  input  logic [FILT_W-1:0]      filt_len,
  input  logic [N_CH-1:0]        clr,
  output logic [N_CH-1:0]        pulse_sig,
  output logic [N_CH-1:0]        pulse_dir,
  output logic [N_CH-1:0]        sticky,
  output logic [CNT_W*N_CH-1:0]  evt_cnt
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .sig      (sig[i]),
      .mode     (mode[MODE_W*i +: MODE_W]),
      .filt_len (filt_len),
      .clr      (clr[i]),
      .pulse_sig(pulse_sig[i]),
      .pulse_dir(pulse_dir[i]),
      .sticky   (sticky[i]),
      .evt_cnt  (evt_cnt[CNT_W*i +: CNT_W])
    );
  end
endmodule

// File: doc/multi_edge_det.md
# multi_edge_det

Parametrised, multi-channel successor to the single-bit pulse detector. Each channel synchronises an asynchronous input, removes glitches with a programmable stability filter, and detects rising, falling or both edges per channel. On each detected edge it emits a one-cycle pulse with direction, sets a sticky flag and increments a saturating event counter. It sits between raw external/status lines and the interrupt/status logic.

## Interface
- N_CH, 4, number of independent channels
- SYNC_STAGES, 2, synchroniser depth (legal ≥ 2)
- FILT_W, 4, width of filter length / stability counter
- CNT_W, 8, width of per-channel event counter

- clk  in  1  single clock; one clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- sig  in  N_CH  raw asynchronous inputs, bit i = channel i
- mode  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- filt_len  in  FILT_W  common stability length L in cycles (0 = no filtering)
- clr  in  N_CH  per-channel synchronous clear of sticky flag and counter
- pulse_sig  out  N_CH  one-cycle edge pulse
- pulse_dir  out  N_CH  direction of current pulse: 1 rise, 0 fall; valid only with pulse_sig
- sticky  out  N_CH  latched "edge seen" flag
- evt_cnt  out  CNT_W*N_CH  per-channel saturating edge count, channel i at [CNT_W*(i+1)-1 : CNT_W*i]

## Operation
- Per channel: synchroniser (SYNC_STAGES flops) -> stability filter -> edge qualifier -> status.
- Filter holds registered level `filt` and counter `stab`:
  - sync output == filt: stab <= 0.
  - sync output != filt and stab >= L: filt <= sync output, stab <= 0, raise update event.
  - otherwise stab <= stab + 1.
  - Compare is ≥, so lowering filt_len mid-count completes on the next cycle; no wrap.
- Qualifier: on an update event, pulse_sig <= 1 when mode matches the direction (rise: new filt = 1; fall: new filt = 0; both: either); pulse_dir <= new filt. Otherwise pulse_sig <= 0, pulse_dir holds.
- Filter runs regardless of mode; mode 00 suppresses pulses only. Enabling a channel never produces a pulse from stale history.
- Sticky: set on pulse_sig assertion; cleared by clr; simultaneous clr and pulse -> sticky = 1 (set wins).
- evt_cnt: +1 per pulse, saturates at 2^CNT_W-1; clr sets 0; simultaneous clr and pulse -> 1.
- Channels are fully independent; only filt_len is shared.

## Timing
- Reset: sync flops, filt, stab, pulse_sig, pulse_dir, sticky, evt_cnt all 0. A sig held high through reset release produces a rising update after the normal latency.
- Latency: if edge k is the first edge sampling a new stable sig level, the update event occurs and pulse_sig is high for exactly one cycle after edge k + SYNC_STAGES + L - 1 + 1 = k + SYNC_STAGES + L.
- A level must be seen stable at the sync output for L+1 consecutive cycles to be accepted. Shorter excursions produce no pulse and no filt change.
- Minimum spacing between pulses on one channel is L+1 cycles. Toggling every cycle with L = 0 yields a pulse every cycle.
- sticky and evt_cnt reflect a pulse on the edge after pulse_sig asserts. clr acts on the edge where it is sampled.
- rstn assertion mid-operation clears everything immediately (asynchronously). A filter count in progress is lost.

## Structure
- Shared package edge_det_pkg:
  - mode_e enum: EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - Mode field width constant (2).
- Sub-module edge_det_ch contains the synchroniser, filter, qualifier, sticky flag and counter for one channel. The top is a generate loop over N_CH plus port slicing.

## Test plan
- Reset then sig[0] 0->1 with L=0, mode rise -> pulse_sig[0]=1 and pulse_dir[0]=1 for one cycle, 2 cycles after the sampling edge; sticky[0]=1; evt_cnt[0]=1.
- L=3, mode both, 2-cycle glitch on sig[1] -> no pulse, evt_cnt[1]=0. A 4-cycle-stable change -> one pulse at SYNC_STAGES+3 cycles.
- mode fall on ch2, sig[2] 0->1->0 with both levels stable -> a single pulse with pulse_dir=0; evt_cnt[2]=1.
- Mode off on ch3 while toggling, then switch to rise -> no pulses while off. The next true rising edge gives exactly one pulse.
- CNT_W=8, drive 300 rising edges -> evt_cnt saturates at 255. clr coincident with a pulse -> evt_cnt=1, sticky=1.
- rstn asserted mid-filter count (L=7, stab=4) -> all outputs 0 immediately. After release, sig still high -> a rising pulse after the full SYNC_STAGES+7 latency.
